game_status_display: RTL and testbench
======================================

# game_status_display

Parametrised game-status overlay for the LED-matrix display. It tracks remaining lives and flashes the display on each hit. When lives run out it latches a GAME OVER pattern; when the player wins it latches a WIN pattern. It sits between the collision/goal logic and the row mux of the matrix driver. It emits one WIDTH-bit overlay row for the row index currently being scanned.

## Interface

Parameters:
- WIDTH, 16 — pixels per row.
- ROWS, 16 — number of display rows; row index width is $clog2(ROWS).
- LIVES, 3 — starting lives, ≥1.
- FLASH_TICKS, 8 — tick pulses spent in the HIT flash state, ≥2.
- BLINK_TICKS, 16 — tick pulses per blink half-period (used only with the blink macro), ≥1.
- PATTERN, 16'b1011111110010111 — GAME OVER row pattern, WIDTH bits.
- ROW_LO, 6 / ROW_HI, 9 — inclusive row range that shows PATTERN in OVER.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame-rate enable.
- hit  in  1  collision pulse/level.
- win  in  1  goal-reached pulse/level.
- restart  in  1  player restart request.
- row  in  $clog2(ROWS)  row currently scanned.
- pixels  out  WIDTH  overlay row for `row`; OR-ed into the frame by the driver.
- lives_left  out  $clog2(LIVES+1)  remaining lives.
- game_over  out  1  high in OVER.
- game_won  out  1  high in WIN.
- freeze  out  1  high in any state except PLAY; halts game motion.

## Operation

- States: PLAY, HIT, OVER, WIN. Reset value of each output:
  - state = PLAY, lives_left = LIVES;
  - flash counter = 0, blink counter = 0, blink phase = 0;
  - pixels = 0, game_over = 0, game_won = 0, freeze = 0.
- PLAY:
  - hit with lives_left > 1 → HIT; lives_left decrements; flash counter loads FLASH_TICKS.
  - hit with lives_left == 1 → OVER; lives_left = 0.
  - win without hit → WIN.
  - hit and win in the same cycle: hit has priority.
- HIT:
  - hit, win and restart are ignored (invulnerability).
  - Each tick decrements the flash counter.
  - A tick while the counter == 1 → PLAY, and the counter becomes 0.
- OVER and WIN are absorbing. restart → PLAY, lives_left = LIVES, counters cleared.
- restart in PLAY or HIT is ignored. hit and win in OVER or WIN are ignored.
- pixels, combinational from state, row and counters:
  - PLAY: 0.
  - HIT: all-ones when flash counter bit0 == 1, else 0.
  - OVER: PATTERN when ROW_LO ≤ row ≤ ROW_HI, else 0 (subject to blink, see Configuration).
  - WIN: checkerboard; bit i = (i + row) mod 2.
- lives_left never underflows. It saturates at 0 in OVER.

## Timing

- State, lives_left and counters update on the posedge after the qualifying input is sampled high. There is a 1-cycle latency from hit to freeze=1.
- pixels follows a row change in the same cycle, with no added latency.
- HIT lasts exactly FLASH_TICKS tick pulses. tick pulses arriving in the entry cycle do not count.
- Levels are accepted. A hit held high across HIT→PLAY is taken again on the first PLAY cycle. Callers pulse hit.
- reset mid-HIT or mid-OVER returns to PLAY on the next edge, with all outputs at their reset values.

## Configuration

- GAME_STATUS_BLINK_EN defined:
  - In OVER, the blink counter counts tick pulses and toggles the blink phase every BLINK_TICKS ticks.
  - pixels shows PATTERN only while the phase is 1; the phase is 0 on entry to OVER.
  - The counter and phase clear on leaving OVER.
- Not defined: no blink logic is built, and OVER shows PATTERN steadily.

## Test plan

- Reset, then hit pulse → next cycle: state HIT, lives_left=2, freeze=1. After 8 ticks → PLAY, freeze=0, pixels=0.
- During HIT with row=0: pixels alternates 16'hFFFF/16'h0000 on each tick, starting at 16'h0000 (counter 8).
- Three separated hits → lives_left 2, 1, 0. After the third: game_over=1, pixels=16'hBF97 at row=7, and 16'h0000 at row=3.
- Hit and win asserted together in PLAY with lives_left=3 → HIT, lives_left=2, game_won=0. A win alone later → WIN; at row=0 pixels=16'hAAAA, at row=1 pixels=16'h5555.
- In OVER, hit and win are ignored. restart → PLAY, lives_left=3, game_over=0. Reset asserted mid-HIT → PLAY, lives_left=3.
- With GAME_STATUS_BLINK_EN and BLINK_TICKS=2 in OVER at row=7: pixels is 0 for 2 ticks, then 16'hBF97 for 2 ticks, repeating. Without the macro: steady 16'hBF97.

Source files
------------

// File: rtl/game_status_display.sv
// game_status_display: lives tracking and status overlay for the LED matrix.
// States PLAY / HIT / OVER / WIN. The overlay row is combinational from the state,
// the scanned row and the counters, so it follows the row mux with no added latency.
// Optional feature: define GAME_STATUS_BLINK_EN to blink the GAME OVER pattern.
// The blink period is BLINK_TICKS tick pulses per half-period.
module game_status_display #(
  parameter int               WIDTH       = 16,
  parameter int               ROWS        = 16,
  parameter int               LIVES       = 3,
  parameter int               FLASH_TICKS = 8,
  parameter int               BLINK_TICKS = 16,
  parameter logic [WIDTH-1:0] PATTERN     = 16'b1011111110010111,
  parameter int               ROW_LO      = 6,
  parameter int               ROW_HI      = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       hit,
  input  logic                       win,
  input  logic                       restart,
  input  logic [$clog2(ROWS)-1:0]    row,
  output logic [WIDTH-1:0]           pixels,
  output logic [$clog2(LIVES+1)-1:0] lives_left,
  output logic                       game_over,
  output logic                       game_won,
  output logic                       freeze
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int FW = $clog2(FLASH_TICKS + 1);

  // Parameter sanity check at elaboration.
  if (LIVES < 1 || FLASH_TICKS < 2 || BLINK_TICKS < 1) begin : g_param_check
    $error("game_status_display: invalid LIVES/FLASH_TICKS/BLINK_TICKS");
  end

  typedef enum logic [1:0] {PLAY, HIT, OVER, WIN} state_t;

  state_t        state;
  logic [FW-1:0] flash_cnt;
  logic          blink_show;
  logic          in_band;

  // Game FSM: the state, lives, flash counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      lives_left <= LW'(LIVES);
      flash_cnt  <= '0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
      freeze     <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          // hit takes priority over win when both arrive together
          if (hit) begin
            freeze <= 1'b1;
            if (lives_left > LW'(1)) begin
              state      <= HIT;
              lives_left <= lives_left - LW'(1);
              flash_cnt  <= FW'(FLASH_TICKS);
            end else begin
              state      <= OVER;
              lives_left <= '0;
              game_over  <= 1'b1;
            end
          end else if (win) begin
            state    <= WIN;
            game_won <= 1'b1;
            freeze   <= 1'b1;
          end
        end
        HIT: begin
          // invulnerable: only ticks matter until the flash runs out
          if (tick) begin
            if (flash_cnt == FW'(1)) begin
              state     <= PLAY;
              flash_cnt <= '0;
              freeze    <= 1'b0;
            end else begin
              flash_cnt <= flash_cnt - FW'(1);
            end
          end
        end
        default: begin
          // OVER and WIN hold until the player asks to restart
          if (restart) begin
            state      <= PLAY;
            lives_left <= LW'(LIVES);
            flash_cnt  <= '0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
            freeze     <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef GAME_STATUS_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Blink timer: runs only in OVER, starts dark, toggles every BLINK_TICKS ticks.
  always_ff @(posedge clk) begin
    if (reset || state != OVER) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blink_show = blink_phase;
`else
  assign blink_show = 1'b1;
`endif

  assign in_band = (int'(row) >= ROW_LO) && (int'(row) <= ROW_HI);

  // Overlay row: a function of the state, the scanned row and the counters.
  always_comb begin
    pixels = '0;
    case (state)
      HIT:  if (flash_cnt[0]) pixels = '1;
      OVER: if (in_band && blink_show) pixels = PATTERN;
      WIN: begin
        for (int i = 0; i < WIDTH; i++) pixels[i] = i[0] ^ row[0];
      end
      default: pixels = '0;
    endcase
  end

endmodule

// File: tb/tb_game_status_display.sv
module tb_game_status_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        hit = 1'b0;
  logic        win = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  row = 4'd0;
  logic [15:0] pixels;
  logic [1:0]  lives_left;
  logic        game_over;
  logic        game_won;
  logic        freeze;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [15:0] PAT = 16'hBF97;
`ifdef GAME_STATUS_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  game_status_display #(
    .WIDTH(16), .ROWS(16), .LIVES(3), .FLASH_TICKS(8), .BLINK_TICKS(2),
    .PATTERN(16'b1011111110010111), .ROW_LO(6), .ROW_HI(9)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .hit(hit), .win(win),
    .restart(restart), .row(row), .pixels(pixels), .lives_left(lives_left),
    .game_over(game_over), .game_won(game_won), .freeze(freeze)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // one clock edge; inputs change and outputs are sampled 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; hit = 1'b0; win = 1'b0; restart = 1'b0; tick = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    row = 4'd7;
    do_reset();
    n_checks++; if (lives_left !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives_left); end
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL reset_pixels: got %h expected 0000", pixels); end
    n_checks++; if ({game_over, game_won, freeze} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {game_over, game_won, freeze}); end
  endtask

  task automatic test_hit_flash();
    logic [15:0] exp;
    do_reset();
    row = 4'd0;
    // tick in the entry cycle must not count
    hit = 1'b1; tick = 1'b1;
    cyc();
    hit = 1'b0; tick = 1'b0;
    n_checks++; if (lives_left !== 2'd2) begin n_fail++; $display("FAIL hit_lives: got %0d expected 2", lives_left); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL hit_freeze: got %b expected 1", freeze); end
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL hit_entry_pixels: got %h expected 0000", pixels); end
    // invulnerable: hit, win and restart ignored
    hit = 1'b1; win = 1'b1; restart = 1'b1;
    cyc();
    hit = 1'b0; win = 1'b0; restart = 1'b0;
    n_checks++; if ({lives_left, game_won, freeze} !== {2'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL hit_invuln: got lives=%0d won=%b freeze=%b expected 2 0 1", lives_left, game_won, freeze); end
    for (int k = 1; k <= 8; k++) begin
      tick_n(1);
      exp = (k < 8 && ((8 - k) % 2) == 1) ? 16'hFFFF : 16'h0000;
      n_checks++; if (pixels !== exp) begin n_fail++; $display("FAIL flash_pixels tick %0d: got %h expected %h", k, pixels, exp); end
      n_checks++; if (freeze !== (k < 8)) begin n_fail++; $display("FAIL flash_freeze tick %0d: got %b expected %b", k, freeze, (k < 8)); end
    end
    n_checks++; if (lives_left !== 2'd2) begin n_fail++; $display("FAIL flash_end_lives: got %0d expected 2", lives_left); end
  endtask

  task automatic test_lives_to_over();
    logic [15:0] band;
    do_reset();
    for (int h = 1; h <= 3; h++) begin
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      n_checks++; if (lives_left !== 2'(3 - h)) begin n_fail++; $display("FAIL lives_after_hit %0d: got %0d expected %0d", h, lives_left, 3 - h); end
      if (h < 3) tick_n(8);
    end
    n_checks++; if ({game_over, game_won, freeze} !== 3'b101) begin n_fail++; $display("FAIL over_flags: got %b expected 101", {game_over, game_won, freeze}); end
    band = BLINK ? 16'h0000 : PAT;
    row = 4'd7; #1;
    n_checks++; if (pixels !== band) begin n_fail++; $display("FAIL over_row7: got %h expected %h", pixels, band); end
    row = 4'd3; #1;
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL over_row3: got %h expected 0000", pixels); end
    row = 4'd6; #1;
    n_checks++; if (pixels !== band) begin n_fail++; $display("FAIL over_row6: got %h expected %h", pixels, band); end
    row = 4'd9; #1;
    n_checks++; if (pixels !== band) begin n_fail++; $display("FAIL over_row9: got %h expected %h", pixels, band); end
    row = 4'd5; #1;
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL over_row5: got %h expected 0000", pixels); end
    row = 4'd10; #1;
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL over_row10: got %h expected 0000", pixels); end
    // hit and win ignored in OVER
    hit = 1'b1; win = 1'b1;
    cyc();
    hit = 1'b0; win = 1'b0;
    n_checks++; if ({lives_left, game_over, game_won} !== {2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL over_ignore: got lives=%0d over=%b won=%b expected 0 1 0", lives_left, game_over, game_won); end
    // steady or blinking pattern at row 7
    row = 4'd7;
    for (int n = 1; n <= 6; n++) begin
      tick_n(1);
      band = BLINK ? ((((n / 2) % 2) == 1) ? PAT : 16'h0000) : PAT;
      n_checks++; if (pixels !== band) begin n_fail++; $display("FAIL over_blink tick %0d: got %h expected %h", n, pixels, band); end
    end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    n_checks++; if ({lives_left, game_over, freeze} !== {2'd3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL over_restart: got lives=%0d over=%b freeze=%b expected 3 0 0", lives_left, game_over, freeze); end
    n_checks++; if (pixels !== 16'h0000) begin n_fail++; $display("FAIL restart_pixels: got %h expected 0000", pixels); end
  endtask

  task automatic test_hit_win_same_cycle();
    do_reset();
    hit = 1'b1; win = 1'b1;
    cyc();
    hit = 1'b0; win = 1'b0;
    n_checks++; if ({lives_left, game_won, freeze} !== {2'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL hitwin_prio: got lives=%0d won=%b freeze=%b expected 2 0 1", lives_left, game_won, freeze); end
    tick_n(8);
    // restart ignored in PLAY
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    n_checks++; if (lives_left !== 2'd2) begin n_fail++; $display("FAIL play_restart_ignored: got %0d expected 2", lives_left); end
    win = 1'b1;
    cyc();
    win = 1'b0;
    n_checks++; if ({game_won, game_over, freeze} !== 3'b101) begin n_fail++; $display("FAIL win_flags: got %b expected 101", {game_won, game_over, freeze}); end
    row = 4'd0; #1;
    n_checks++; if (pixels !== 16'hAAAA) begin n_fail++; $display("FAIL win_row0: got %h expected AAAA", pixels); end
    row = 4'd1; #1;
    n_checks++; if (pixels !== 16'h5555) begin n_fail++; $display("FAIL win_row1: got %h expected 5555", pixels); end
    row = 4'd14; #1;
    n_checks++; if (pixels !== 16'hAAAA) begin n_fail++; $display("FAIL win_row14: got %h expected AAAA", pixels); end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    n_checks++; if ({lives_left, game_won} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL win_hit_ignored: got lives=%0d won=%b expected 2 1", lives_left, game_won); end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    n_checks++; if ({lives_left, game_won, freeze} !== {2'd3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL win_restart: got lives=%0d won=%b freeze=%b expected 3 0 0", lives_left, game_won, freeze); end
  endtask

  task automatic test_level_hit();
    do_reset();
    hit = 1'b1;
    cyc();
    tick_n(8);
    n_checks++; if ({lives_left, freeze} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL level_exit: got lives=%0d freeze=%b expected 2 0", lives_left, freeze); end
    cyc();
    hit = 1'b0;
    n_checks++; if ({lives_left, freeze} !== {2'd1, 1'b1}) begin n_fail++; $display("FAIL level_retake: got lives=%0d freeze=%b expected 1 1", lives_left, freeze); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    row = 4'd0;
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    tick_n(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++; if ({lives_left, freeze, pixels} !== {2'd3, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL reset_mid_hit: got lives=%0d freeze=%b pixels=%h expected 3 0 0000", lives_left, freeze, pixels); end
    for (int h = 0; h < 3; h++) begin
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      if (h < 2) tick_n(8);
    end
    row = 4'd7;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++; if ({lives_left, game_over, freeze, pixels} !== {2'd3, 1'b0, 1'b0, 16'h0000}) begin n_fail++; $display("FAIL reset_mid_over: got lives=%0d over=%b freeze=%b pixels=%h expected 3 0 0 0000", lives_left, game_over, freeze, pixels); end
  endtask

  initial begin
    test_reset();
    test_hit_flash();
    test_lives_to_over();
    test_hit_win_same_cycle();
    test_level_hit();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
